// File: rtl/runahead_reg_file.sv
// -----------------------------------------------------------------------------
// runahead_reg_file
//
// Architectural register file with a runahead checkpoint for the decode-stage
// read path and the write-back write path of the MIPS core.
//
// Two copies of the register file are kept:
//   arch   - the architectural state. It is frozen while in runahead.
//   shadow - the speculative state. It is read and written during runahead,
//            and each entry carries an INV (poison) bit.
// When runahead is left, a restore FSM copies arch into shadow, one group of
// COPY_PER_CYCLE registers per cycle, so that shadow matches arch again.
//
// Ports:
//   clk           clock
//   rst_n         synchronous active-low reset
//   rd_en         per-port read enable
//   rd_addr       packed read addresses, port p = [p*ADDR_WIDTH +: ADDR_WIDTH]
//   rd_data       packed read data,      port p = [p*DATA_WIDTH +: DATA_WIDTH]
//   rd_inv        INV bit of the register read (0 outside runahead)
//   wr_en         write-back valid
//   wr_addr       write address
//   wr_data       write data
//   wr_inv        write result is poisoned (used only in runahead)
//   ra_enter      pulse: enter runahead
//   ra_exit       pulse: leave runahead
//   ra_mode       high while in RUNAHEAD
//   restore_busy  high while in RESTORE
// -----------------------------------------------------------------------------
module runahead_reg_file #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_REGS       = 32,
    parameter int ADDR_WIDTH     = $clog2(NUM_REGS),
    parameter int NUM_READ       = 2,
    parameter int COPY_PER_CYCLE = 8,
    parameter int BYPASS         = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_READ-1:0]            rd_en,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_READ-1:0]            rd_inv,
    input  logic                           wr_en,
    input  logic [ADDR_WIDTH-1:0]          wr_addr,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic                           wr_inv,
    input  logic                           ra_enter,
    input  logic                           ra_exit,
    output logic                           ra_mode,
    output logic                           restore_busy
);

    // Number of restore cycles and the width of the group counter.
    localparam int NUM_GROUPS = NUM_REGS / COPY_PER_CYCLE;
    localparam int CNT_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;

    localparam logic [1:0] ST_NORMAL   = 2'd0;
    localparam logic [1:0] ST_RUNAHEAD = 2'd1;
    localparam logic [1:0] ST_RESTORE  = 2'd2;

    logic [1:0]            state;
    logic [CNT_W-1:0]      restore_cnt;
    logic [DATA_WIDTH-1:0] arch   [NUM_REGS];
    logic [DATA_WIDTH-1:0] shadow [NUM_REGS];
    logic [NUM_REGS-1:0]   inv_q;

    // Register 0 is hardwired, so writes to it are dropped in every state.
    logic                  wr_ok;
    logic [ADDR_WIDTH-1:0] group_base;
    logic                  last_group;

    assign wr_ok      = wr_en && (wr_addr != '0);
    assign group_base = ADDR_WIDTH'(restore_cnt) * ADDR_WIDTH'(COPY_PER_CYCLE);
    assign last_group = (restore_cnt == CNT_W'(NUM_GROUPS - 1));

    // The state register itself is the decode source, so both flags change
    // the cycle after the triggering pulse.
    assign ra_mode      = (state == ST_RUNAHEAD);
    assign restore_busy = (state == ST_RESTORE);

    // -------------------------------------------------------------------------
    // Read ports
    // -------------------------------------------------------------------------
    for (genvar p = 0; p < NUM_READ; p++) begin : g_read
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic                  inv;
        logic                  byp_hit;

        assign addr    = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
        assign byp_hit = (BYPASS != 0) && wr_ok && (wr_addr == addr);

        // NOTE: every output of a combinational block gets a default at the
        // top; a path that leaves one unassigned would infer a latch.
        always_comb begin
            data = '0;
            inv  = 1'b0;
            if (rd_en[p] && (addr != '0)) begin
                if (byp_hit) begin
                    data = wr_data;
                    inv  = (state == ST_RUNAHEAD) ? wr_inv : 1'b0;
                end else if (state == ST_RUNAHEAD) begin
                    data = shadow[addr];
                    inv  = inv_q[addr];
                end else begin
                    data = arch[addr];
                end
            end
        end

        assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = data;
        assign rd_inv[p]                           = inv;
    end

    // -------------------------------------------------------------------------
    // State, storage and restore sequencing
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side sees the pre-edge values. This is also what lets the
    // restore copy below read old arch, and lets a later write to the same
    // shadow entry in this block override the copy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_NORMAL;
            restore_cnt <= '0;
            // NOTE: the storage arrays are reset here because the register
            // file must read back as all-zero after reset; a plain data RAM
            // would normally be left unreset.
            arch        <= '{default: '0};
            shadow      <= '{default: '0};
            inv_q       <= '0;
        end else begin
            case (state)
                ST_NORMAL: begin
                    if (wr_ok) begin
                        arch[wr_addr]   <= wr_data;
                        shadow[wr_addr] <= wr_data;
                        inv_q[wr_addr]  <= 1'b0;
                    end
                    // ra_exit has no meaning here; ra_enter wins when both
                    // pulses arrive together.
                    if (ra_enter) begin
                        state <= ST_RUNAHEAD;
                    end
                end

                ST_RUNAHEAD: begin
                    if (wr_ok) begin
                        shadow[wr_addr] <= wr_data;
                        inv_q[wr_addr]  <= wr_inv;
                    end
                    if (ra_exit) begin
                        state       <= ST_RESTORE;
                        restore_cnt <= '0;
                    end
                end

                ST_RESTORE: begin
                    for (int i = 0; i < COPY_PER_CYCLE; i++) begin
                        shadow[group_base + ADDR_WIDTH'(i)] <= arch[group_base + ADDR_WIDTH'(i)];
                        inv_q[group_base + ADDR_WIDTH'(i)]  <= 1'b0;
                    end
                    // Placed after the copy so a write into the group being
                    // copied this cycle lands in shadow.
                    if (wr_ok) begin
                        arch[wr_addr]   <= wr_data;
                        shadow[wr_addr] <= wr_data;
                        inv_q[wr_addr]  <= 1'b0;
                    end
                    if (last_group) begin
                        restore_cnt <= '0;
                        state       <= ST_NORMAL;
                    end else begin
                        restore_cnt <= restore_cnt + 1'b1;
                    end
                end

                default: begin
                    state       <= ST_NORMAL;
                    restore_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_runahead_reg_file.sv
// -----------------------------------------------------------------------------
// tb_runahead_reg_file
//
// Directed bench for runahead_reg_file. Two instances share all inputs: one
// with same-cycle forwarding enabled, one without, so the forwarding
// difference is observable on identical stimulus. Expected values are written
// out by hand at each step.
// -----------------------------------------------------------------------------
module tb_runahead_reg_file;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int AW = 5;
    localparam int NP = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NP-1:0]    rd_en;
    logic [NP*AW-1:0] rd_addr;
    logic [NP*DW-1:0] rd_data_b, rd_data_n;
    logic [NP-1:0]    rd_inv_b, rd_inv_n;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic             wr_inv;
    logic             ra_enter, ra_exit;
    logic             ra_mode_b, ra_mode_n;
    logic             busy_b, busy_n;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    runahead_reg_file #(.DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_READ(NP),
                        .COPY_PER_CYCLE(8), .BYPASS(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_b), .rd_inv(rd_inv_b), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_inv(wr_inv),
        .ra_enter(ra_enter), .ra_exit(ra_exit), .ra_mode(ra_mode_b),
        .restore_busy(busy_b)
    );

    runahead_reg_file #(.DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_READ(NP),
                        .COPY_PER_CYCLE(8), .BYPASS(0)) u_dut_nb (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_n), .rd_inv(rd_inv_n), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_inv(wr_inv),
        .ra_enter(ra_enter), .ra_exit(ra_exit), .ra_mode(ra_mode_n),
        .restore_busy(busy_n)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then step off the edge before driving or sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int p, input logic en, input logic [AW-1:0] a);
        rd_en[p]            = en;
        rd_addr[p*AW +: AW] = a;
    endtask

    task automatic set_wr(input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic inv);
        wr_en   = en;
        wr_addr = a;
        wr_data = d;
        wr_inv  = inv;
    endtask

    function automatic logic [DW-1:0] data_b(input int p);
        return rd_data_b[p*DW +: DW];
    endfunction

    function automatic logic [DW-1:0] data_n(input int p);
        return rd_data_n[p*DW +: DW];
    endfunction

    initial begin
        rst_n    = 1'b0;
        rd_en    = '0;
        rd_addr  = '0;
        ra_enter = 1'b0;
        ra_exit  = 1'b0;
        set_wr(1'b0, '0, '0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state.
        set_rd(0, 1'b1, 5'd5);
        set_rd(1, 1'b1, 5'd9);
        #1;
        check("rst_ra_mode", DW'(ra_mode_b), 0);
        check("rst_busy",    DW'(busy_b), 0);
        check("rst_r5",      data_b(0), 0);
        check("rst_r9",      data_b(1), 0);

        // Write r5 = 0x1234 and read it back on both ports.
        set_wr(1'b1, 5'd5, 32'h1234, 1'b0);
        tick();
        set_wr(1'b0, '0, '0, 1'b0);
        set_rd(1, 1'b1, 5'd5);
        #1;
        check("r5_p0",     data_b(0), 32'h1234);
        check("r5_p1",     data_b(1), 32'h1234);
        check("r5_inv",    DW'(rd_inv_b), 0);
        check("r5_nb_p0",  data_n(0), 32'h1234);

        // r0 is hardwired: write dropped, same-cycle read not forwarded.
        set_wr(1'b1, 5'd0, 32'hFFFF, 1'b0);
        set_rd(0, 1'b1, 5'd0);
        #1;
        check("r0_byp", data_b(0), 0);
        tick();
        set_wr(1'b0, '0, '0, 1'b0);
        #1;
        check("r0_read", data_b(0), 0);

        // Disabled port returns 0 even for a nonzero register.
        set_rd(1, 1'b0, 5'd5);
        #1;
        check("rd_dis", data_b(1), 0);

        // Forwarding: r7 = 0x11, then write 0xAA while reading r7.
        set_wr(1'b1, 5'd7, 32'h11, 1'b0);
        tick();
        set_wr(1'b1, 5'd7, 32'hAA, 1'b0);
        set_rd(0, 1'b1, 5'd7);
        #1;
        check("byp_on",  data_b(0), 32'hAA);
        check("byp_off", data_n(0), 32'h11);
        tick();
        set_wr(1'b0, '0, '0, 1'b0);
        #1;
        check("byp_off_later", data_n(0), 32'hAA);

        // Pre-runahead arch values r3 = 0x33, r2 = 0x22.
        set_wr(1'b1, 5'd3, 32'h33, 1'b0);
        tick();
        set_wr(1'b1, 5'd2, 32'h22, 1'b0);
        tick();

        // ra_exit in NORMAL is ignored.
        set_wr(1'b0, '0, '0, 1'b0);
        ra_exit = 1'b1;
        tick();
        ra_exit = 1'b0;
        #1;
        check("exit_in_normal_busy", DW'(busy_b), 0);
        check("exit_in_normal_mode", DW'(ra_mode_b), 0);

        // Enter runahead with a write in the same cycle (commits to both).
        ra_enter = 1'b1;
        set_wr(1'b1, 5'd4, 32'h44, 1'b0);
        #1;
        check("enter_mode_delay", DW'(ra_mode_b), 0);
        tick();
        ra_enter = 1'b0;
        set_wr(1'b0, '0, '0, 1'b0);
        set_rd(0, 1'b1, 5'd4);
        #1;
        check("ra_mode_on", DW'(ra_mode_b), 1);
        check("ra_r4",      data_b(0), 32'h44);

        // Poisoned write in runahead; forwarded inv seen the same cycle.
        set_wr(1'b1, 5'd3, 32'h55, 1'b1);
        set_rd(0, 1'b1, 5'd3);
        #1;
        check("ra_byp_data", data_b(0), 32'h55);
        check("ra_byp_inv",  DW'(rd_inv_b[0]), 1);
        tick();
        set_wr(1'b0, '0, '0, 1'b0);
        #1;
        check("ra_r3_data", data_b(0), 32'h55);
        check("ra_r3_inv",  DW'(rd_inv_b[0]), 1);

        // Exit: RESTORE cycle 0 begins after this edge.
        ra_exit = 1'b1;
        tick();
        ra_exit = 1'b0;
        #1;
        check("rs0_busy", DW'(busy_b), 1);
        check("rs0_mode", DW'(ra_mode_b), 0);
        check("rs0_r3",   data_b(0), 32'h33);
        check("rs0_inv",  DW'(rd_inv_b[0]), 0);
        set_wr(1'b1, 5'd2, 32'h99, 1'b0);
        tick();
        set_wr(1'b0, '0, '0, 1'b0);
        ra_enter = 1'b1;
        #1;
        check("rs1_busy", DW'(busy_b), 1);
        tick();
        ra_enter = 1'b0;
        #1;
        check("rs2_busy", DW'(busy_b), 1);
        check("rs2_mode", DW'(ra_mode_b), 0);
        tick();
        check("rs3_busy", DW'(busy_b), 1);
        tick();
        check("rs_done_busy", DW'(busy_b), 0);
        check("rs_done_mode", DW'(ra_mode_b), 0);

        // Arch after restore.
        set_rd(0, 1'b1, 5'd3);
        set_rd(1, 1'b1, 5'd2);
        #1;
        check("post_r3", data_b(0), 32'h33);
        check("post_r2", data_b(1), 32'h99);

        // Shadow after restore, seen through a fresh runahead.
        ra_enter = 1'b1;
        tick();
        ra_enter = 1'b0;
        #1;
        check("sh_mode",   DW'(ra_mode_b), 1);
        check("sh_r3",     data_b(0), 32'h33);
        check("sh_r3_inv", DW'(rd_inv_b[0]), 0);
        check("sh_r2",     data_b(1), 32'h99);

        // Reset during RESTORE cycle 2.
        ra_exit = 1'b1;
        tick();
        ra_exit = 1'b0;
        tick();
        tick();
        check("pre_rst_busy", DW'(busy_b), 1);
        rst_n = 1'b0;
        tick();
        #1;
        check("rst_abort_busy", DW'(busy_b), 0);
        check("rst_abort_mode", DW'(ra_mode_b), 0);
        check("rst_abort_r3",   data_b(0), 0);
        check("rst_abort_r2",   data_b(1), 0);
        rst_n = 1'b1;
        tick();

        // Simultaneous enter/exit in NORMAL: enter wins.
        ra_enter = 1'b1;
        ra_exit  = 1'b1;
        tick();
        ra_enter = 1'b0;
        ra_exit  = 1'b0;
        #1;
        check("both_mode", DW'(ra_mode_b), 1);
        check("both_busy", DW'(busy_b), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
